fnd_display_8bit: RTL and testbench
===================================

# fnd_display_8bit

Downstream consumer of the 8-bit data register on the Basys3 datapath. It shows the register's output value as an unsigned decimal number, 0–255, on the 4-digit 7-segment (FND) display. An iterative shift-add-3 (double-dabble) FSM converts each new value to BCD. A prescaled scan counter time-multiplexes the digits, with optional leading-zero blanking.

## Interface
Parameters:
- CLK_DIV, 100_000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- data  in  8  unsigned value to display, normally the data register's output.
- blank_lz  in  1  1 = blank leading zeros.
- busy  out  1  high while a conversion is in progress.
- fnd_com  out  4  digit enables, active-low; bit0 = rightmost digit.
- fnd_data  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- **Reset** (rst=0 at an edge):
  - FSM goes to IDLE; prescaler = 0; digit index = 0.
  - Display regs (hund/tens/ones) = 0; busy = 0; fnd_com = 4'b1111; fnd_data = 8'hFF.
  - Force flag set, so a conversion starts on the first edge after release.
- **Converter FSM**, states IDLE, SHIFT, DONE:
  - IDLE: if (data != last_conv) or force, then:
    - capture data into bin_sh; clear the 12-bit BCD accumulator; clear force;
    - bit count = 0; go to SHIFT.
  - SHIFT, one bit per cycle, for exactly 8 cycles:
    - each BCD nibble ≥ 5 gets +3;
    - then {bcd, bin_sh} shifts left 1;
    - after the 8th shift, go to DONE.
  - DONE: copy the BCD nibbles to the display regs; last_conv = captured value; go to IDLE.
  - Changes on data while in SHIFT or DONE are ignored. IDLE re-compares against last_conv, so the final value is always converted.
  - busy = 1 exactly when the state is SHIFT or DONE (registered with the state).
- **Scan**:
  - Prescaler counts 0..CLK_DIV-1 and wraps. At the terminal count, the digit index advances 0→1→2→3→0.
  - Digit 0 = ones, com 4'b1110.
  - Digit 1 = tens, com 4'b1101.
  - Digit 2 = hundreds, com 4'b1011.
  - Digit 3 = thousands, com 4'b0111, always blank (8'hFF).
- **Segment codes** (dp always off, bit7 = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- **Blanking** (blank_lz=1):
  - hundreds = 0 → hundreds slot shows 8'hFF;
  - hundreds = 0 and tens = 0 → tens slot shows 8'hFF;
  - the ones digit is never blanked.
  - blank_lz is sampled combinationally each cycle; no conversion is needed for it to take effect.

## Timing
- Change latency:
  - data differs from last_conv at IDLE edge N;
  - SHIFT occupies edges N+1..N+8;
  - DONE at edge N+9 updates the display regs;
  - fnd_data reflects the new value from edge N+10 while the relevant digit is selected.
- fnd_com and fnd_data are registered. They follow the digit index and display regs with 1-cycle lag.
- Each digit is held for exactly CLK_DIV cycles. The full refresh period is 4·CLK_DIV cycles.
- After reset release, at edge 1:
  - fnd_com = 1110 and ones shows the converted-so-far value (0 → C0);
  - conversion runs at edges 1–9 with busy high.
- Reset asserted mid-SHIFT aborts the conversion. The display regs clear, and a fresh conversion of the current data starts after release.
- The prescaler and scan run independently of the FSM. The display never blanks or glitches during conversion; it keeps the previous value until DONE.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset**: rst=0 for 3 cycles, data=0 → fnd_com=1111, fnd_data=FF, busy=0. After release, busy=1 for 9 cycles; then the ones slot shows C0 and, with blank_lz=1, the tens/hundreds slots show FF.
- **Max value**: data=255 → after 10 cycles the scan shows ones 92, tens 92, hundreds A4, digit3 FF.
- **Blanking**: data=7 with blank_lz=1 → FF, FF, F8 (hundreds, tens, ones). Switching to blank_lz=0 → C0, C0, F8 on the next scan pass. data=100 with blank_lz=1 → F9, C0, C0.
- **Change mid-conversion**: data=100, then 42 on the 3rd busy cycle → display shows 100 after the first DONE; busy goes low for one IDLE cycle, a second conversion follows, and the display shows 42 (FF, 99, A4).
- **Scan order**: fnd_com sequence 1110→1101→1011→0111→1110, each held 4 cycles.
- **Reset mid-SHIFT**: data=200; assert rst on the 4th busy cycle → display regs 0. After release, a full 9-cycle busy window, then 200 displays (A4, C0, C0).

Source files
------------

// File: rtl/fnd_display_8bit.sv
// Shows an 8-bit unsigned value (0-255) in decimal on a 4-digit active-low 7-segment display.
// A shift-add-3 FSM converts each new value to BCD; a prescaled scan multiplexes the digits.
module fnd_display_8bit #(
   parameter int CLK_DIV = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       blank_lz,
   output logic       busy,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t        state, state_next;
   logic [7:0]    bin_sh, cap, last_conv;
   logic [11:0]   bcd, bcd_adj;
   logic [2:0]    bit_cnt;
   logic          force_conv;
   logic          start;
   logic [3:0]    hund, tens, ones;
   logic [PW-1:0] prescale;
   logic [1:0]    digit_idx;
   logic [3:0]    com_next;
   logic [7:0]    seg_next;

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      start      = (data != last_conv) || force_conv;
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         force_conv <= 1'b1;
         bin_sh     <= '0;
         cap        <= '0;
         last_conv  <= '0;
         bcd        <= '0;
         bit_cnt    <= '0;
         hund       <= '0;
         tens       <= '0;
         ones       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bin_sh     <= data;
               cap        <= data;
               bcd        <= '0;
               bit_cnt    <= '0;
               force_conv <= 1'b0;
            end
            SHIFT: begin
               {bcd, bin_sh} <= {bcd_adj[10:0], bin_sh, 1'b0};
               bit_cnt       <= bit_cnt + 3'd1;
            end
            DONE: begin
               hund      <= bcd[11:8];
               tens      <= bcd[7:4];
               ones      <= bcd[3:0];
               last_conv <= cap;
            end
            default: ;
         endcase
      end
   end

   // The scan runs free of the converter, so the display keeps the old value until DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescale  <= '0;
         digit_idx <= '0;
      end else if (prescale == PW'(CLK_DIV - 1)) begin
         prescale  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   always_comb begin
      com_next = 4'b1111;
      seg_next = 8'hFF;
      case (digit_idx)
         2'd0: begin
            com_next = 4'b1110;
            seg_next = seg_of(ones);
         end
         2'd1: begin
            com_next = 4'b1101;
            seg_next = (blank_lz && hund == 4'd0 && tens == 4'd0) ? 8'hFF : seg_of(tens);
         end
         2'd2: begin
            com_next = 4'b1011;
            seg_next = (blank_lz && hund == 4'd0) ? 8'hFF : seg_of(hund);
         end
         default: begin
            com_next = 4'b0111;
            seg_next = 8'hFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fnd_com  <= 4'b1111;
         fnd_data <= 8'hFF;
      end else begin
         fnd_com  <= com_next;
         fnd_data <= seg_next;
      end
   end

endmodule

// File: tb/tb_fnd_display_8bit.sv
// Directed bench for fnd_display_8bit with CLK_DIV=4; outputs are sampled on the falling edge.
module tb_fnd_display_8bit;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = 8'd0;
   logic       blank_lz = 1'b0;
   logic       busy;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   fnd_display_8bit #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .data     (data),
      .blank_lz (blank_lz),
      .busy     (busy),
      .fnd_com  (fnd_com),
      .fnd_data (fnd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected segment byte for whichever digit is currently enabled.
   function automatic logic [7:0] pick(input logic [3:0] com, input logic [7:0] e_h,
                                       input logic [7:0] e_t, input logic [7:0] e_o);
      case (com)
         4'b1110: return e_o;
         4'b1101: return e_t;
         4'b1011: return e_h;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic wait_com(input logic [3:0] p, input string tag);
      int k = 0;
      while (fnd_com !== p && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, " com"}, fnd_com, p);
   endtask

   task automatic scan_check(input string tag, input logic [7:0] e_h,
                             input logic [7:0] e_t, input logic [7:0] e_o);
      @(negedge clk);
      wait_com(4'b1110, tag); check({tag, " ones"}, fnd_data, e_o);
      wait_com(4'b1101, tag); check({tag, " tens"}, fnd_data, e_t);
      wait_com(4'b1011, tag); check({tag, " hund"}, fnd_data, e_h);
      wait_com(4'b0111, tag); check({tag, " dig3"}, fnd_data, 8'hFF);
   endtask

   // Waits for busy to rise, then counts busy-high samples; returns on the first low sample.
   task automatic count_busy(output int cnt);
      int k = 0;
      while (busy !== 1'b1 && k < 5) begin
         @(negedge clk);
         k++;
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for 3 cycles.
      rst = 1'b0; data = 8'd0; blank_lz = 1'b1;
      repeat (3) @(negedge clk);
      check("rst com", fnd_com, 4'b1111);
      check("rst seg", fnd_data, 8'hFF);
      check("rst busy", busy, 1'b0);

      rst = 1'b1;
      @(negedge clk);
      check("edge1 com", fnd_com, 4'b1110);
      check("edge1 seg", fnd_data, 8'hC0);
      check("edge1 busy", busy, 1'b1);
      n = 1;
      @(negedge clk);
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("post-reset busy len", n, 9);
      scan_check("zero", 8'hFF, 8'hFF, 8'hC0);

      // Maximum value.
      data = 8'd255;
      count_busy(n);
      check("255 busy len", n, 9);
      scan_check("255", 8'hA4, 8'h92, 8'h92);

      // Leading-zero blanking, then blanking switched off without a conversion.
      data = 8'd7;
      count_busy(n);
      check("7 busy len", n, 9);
      scan_check("7 blank", 8'hFF, 8'hFF, 8'hF8);
      blank_lz = 1'b0;
      scan_check("7 noblank", 8'hC0, 8'hC0, 8'hF8);

      // Data change during a conversion is picked up by a second conversion.
      blank_lz = 1'b1;
      data = 8'd100;
      begin
         int k = 0;
         while (busy !== 1'b1 && k < 5) begin
            @(negedge clk);
            k++;
         end
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (n == 3) data = 8'd42;
         @(negedge clk);
      end
      check("mid first busy len", n, 9);
      check("mid idle gap", busy, 1'b0);
      @(negedge clk);
      check("mid second start", busy, 1'b1);
      check("mid shows 100", fnd_data, pick(fnd_com, 8'hF9, 8'hC0, 8'hC0));
      n = 1;
      @(negedge clk);
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("mid second busy len", n, 9);
      scan_check("42", 8'hFF, 8'h99, 8'hA4);

      // Zero tens/ones under a non-zero hundreds digit stay visible.
      data = 8'd100;
      count_busy(n);
      check("100 busy len", n, 9);
      scan_check("100 blank", 8'hF9, 8'hC0, 8'hC0);

      // Scan order and hold time.
      wait_com(4'b0111, "scan sync");
      wait_com(4'b1110, "scan sync");
      for (int d = 0; d < 4; d++) begin
         logic [3:0] pats [4];
         pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
         for (int j = 0; j < CLK_DIV; j++) begin
            check($sformatf("scan d%0d c%0d", d, j), fnd_com, pats[d]);
            @(negedge clk);
         end
      end
      check("scan wrap", fnd_com, 4'b1110);

      // Reset asserted on the 4th busy cycle aborts the conversion.
      data = 8'd200;
      begin
         int k = 0;
         while (busy !== 1'b1 && k < 5) begin
            @(negedge clk);
            k++;
         end
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (n == 4) begin
            rst = 1'b0;
            break;
         end
         @(negedge clk);
      end
      check("abort at cycle", n, 4);
      @(negedge clk);
      check("abort busy", busy, 1'b0);
      check("abort com", fnd_com, 4'b1111);
      check("abort seg", fnd_data, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort regs cleared com", fnd_com, 4'b1110);
      check("abort regs cleared seg", fnd_data, 8'hC0);
      n = (busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("abort rerun busy len", n, 9);
      scan_check("200", 8'hA4, 8'hC0, 8'hC0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
